// File: rtl/holy_core_pkg.sv
// Shared core types: ALU control codes plus the ALU arbiter state encoding and limits.
package holy_core_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_SLL  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SRL  = 4'b0110,
      ALU_SLTU = 4'b0111,
      ALU_XOR  = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_control_t;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_HOLD = 1'b1
   } alu_arb_state_t;

   localparam int ALU_ARB_MAX_REQ = 8;

endpackage

// File: rtl/alu.sv
// Core integer ALU, purely combinational; undefined control codes yield 0 (zero flag set).
module alu
   import holy_core_pkg::*;
(
   input  alu_control_t alu_control,
   input  logic [31:0]  src1,
   input  logic [31:0]  src2,
   output logic [31:0]  alu_result,
   output logic         zero,
   output logic         last_bit,
   output logic [31:0]  aligned_addr
);

   always_comb begin
      alu_result = 32'd0;
      case (alu_control)
         ALU_ADD:  alu_result = src1 + src2;
         ALU_SUB:  alu_result = src1 - src2;
         ALU_AND:  alu_result = src1 & src2;
         ALU_OR:   alu_result = src1 | src2;
         ALU_XOR:  alu_result = src1 ^ src2;
         ALU_SLL:  alu_result = src1 << src2[4:0];
         ALU_SRL:  alu_result = src1 >> src2[4:0];
         ALU_SRA:  alu_result = $unsigned($signed(src1) >>> src2[4:0]);
         ALU_SLT:  alu_result = {31'd0, $signed(src1) < $signed(src2)};
         ALU_SLTU: alu_result = {31'd0, src1 < src2};
         default:  alu_result = 32'd0;
      endcase
   end

   assign zero         = (alu_result == 32'd0);
   assign last_bit     = alu_result[0];
   assign aligned_addr = {alu_result[31:2], 2'b00};

endmodule

// File: rtl/alu_arb_grant.sv
// One-hot requester picker. HOLY_ALU_ARB_RR_EN: search starts at rr_ptr and wraps;
// otherwise fixed priority (lowest index wins) and rr_ptr is ignored.
module alu_arb_grant #(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               grant_any
);

`ifdef HOLY_ALU_ARB_RR_EN
   always_comb begin
      int idx;
      idx       = 0;
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_REQ;
         if (!grant_any && req_valid[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IDX_W'(idx);
            grant_any  = 1'b1;
         end
      end
   end
`else
   logic rr_ptr_unused;
   assign rr_ptr_unused = ^rr_ptr;

   // Scanning downward lets the lowest valid index overwrite any earlier pick.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[k]) begin
            grant     = '0;
            grant[k]  = 1'b1;
            grant_idx = IDX_W'(k);
            grant_any = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU among NUM_REQ valid/ready requesters; accept in N -> rsp_valid in N+1,
// one op/cycle while the owner drains. HOLY_ALU_ARB_RR_EN selects round-robin over fixed priority.
module alu_arbiter
   import holy_core_pkg::*;
#(
   parameter  int NUM_REQ = 2,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req_valid,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic [NUM_REQ*4-1:0]  req_op,
   input  logic [NUM_REQ*32-1:0] req_src1,
   input  logic [NUM_REQ*32-1:0] req_src2,
   output logic [NUM_REQ-1:0]    rsp_valid,
   input  logic [NUM_REQ-1:0]    rsp_ready,
   output logic [31:0]           rsp_result,
   output logic                  rsp_zero,
   output logic                  rsp_last_bit
);

   alu_arb_state_t     state;
   logic [IDX_W-1:0]   owner;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] grant;
   logic               grant_any;
   logic               drain;
   logic               slot_free;
   logic               acc;

   alu_control_t       alu_op;
   logic [31:0]        alu_a;
   logic [31:0]        alu_b;
   logic [31:0]        alu_res;
   logic               alu_zero;
   logic               alu_last;
   logic [31:0]        alu_aligned_addr_unused;

   alu_arb_grant #(.NUM_REQ(NUM_REQ)) u_grant (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .grant_any (grant_any)
   );

   // Only the owner's rsp_ready matters; other bits are ignored.
   assign drain     = (state == ARB_HOLD) & rsp_ready[owner];
   assign slot_free = (state == ARB_IDLE) | drain;
   assign req_ready = grant & {NUM_REQ{slot_free}};
   assign acc       = |(req_valid & req_ready);

   always_comb begin
      alu_op = ALU_ADD;
      alu_a  = 32'd0;
      alu_b  = 32'd0;
      if (grant_any) begin
         alu_op = alu_control_t'(req_op[int'(grant_idx)*4 +: 4]);
         alu_a  = req_src1[int'(grant_idx)*32 +: 32];
         alu_b  = req_src2[int'(grant_idx)*32 +: 32];
      end
   end

   alu u_alu (
      .alu_control  (alu_op),
      .src1         (alu_a),
      .src2         (alu_b),
      .alu_result   (alu_res),
      .zero         (alu_zero),
      .last_bit     (alu_last),
      .aligned_addr (alu_aligned_addr_unused)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ARB_IDLE;
         owner        <= '0;
         rsp_valid    <= '0;
         rsp_result   <= 32'd0;
         rsp_zero     <= 1'b0;
         rsp_last_bit <= 1'b0;
      end else if (acc) begin
         state        <= ARB_HOLD;
         owner        <= grant_idx;
         rsp_valid    <= grant;
         rsp_result   <= alu_res;
         rsp_zero     <= alu_zero;
         rsp_last_bit <= alu_last;
      end else if (drain) begin
         state        <= ARB_IDLE;
         rsp_valid    <= '0;
      end
   end

`ifdef HOLY_ALU_ARB_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= '0;
      end else if (acc) begin
         rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDX_W'(1);
      end
   end
`else
   assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized plus directed bench for alu_arbiter with a queue scoreboard and a
// spec-level arbitration/ALU reference model.
module tb_alu_arbiter;
   import holy_core_pkg::*;

   localparam int N = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [N-1:0]    req_ready;
   logic [N*4-1:0]  req_op = '0;
   logic [N*32-1:0] req_src1 = '0;
   logic [N*32-1:0] req_src2 = '0;
   logic [N-1:0]    rsp_valid;
   logic [N-1:0]    rsp_ready = '0;
   logic [31:0]     rsp_result;
   logic            rsp_zero;
   logic            rsp_last_bit;

   alu_arbiter #(.NUM_REQ(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_src1     (req_src1),
      .req_src2     (req_src2),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_result   (rsp_result),
      .rsp_zero     (rsp_zero),
      .rsp_last_bit (rsp_last_bit)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      int          owner;
      logic [31:0] res;
   } exp_t;
   exp_t q[$];

   // stimulus state per requester
   logic [N-1:0] v  = '0;
   logic [N-1:0] rr = '0;
   logic [3:0]   op [N];
   logic [31:0]  a  [N];
   logic [31:0]  b  [N];
   logic [N-1:0] last_acc = '0;

   // reference model state
   bit           m_hold  = 1'b0;
   int           m_owner = 0;
   int           m_ptr   = 0;
   logic [N-1:0] m_ev;
   logic [N-1:0] m_er;
   int           m_w;
   bit           m_drn;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] alu_ref(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
      case (o)
         ALU_ADD:  return x + y;
         ALU_SUB:  return x - y;
         ALU_AND:  return x & y;
         ALU_OR:   return x | y;
         ALU_XOR:  return x ^ y;
         ALU_SLL:  return x << y[4:0];
         ALU_SRL:  return x >> y[4:0];
         ALU_SRA:  return $unsigned($signed(x) >>> y[4:0]);
         ALU_SLT:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (x < y) ? 32'd1 : 32'd0;
         default:  return 32'd0;
      endcase
   endfunction

   function automatic int pick(input logic [N-1:0] vv, input int ptr);
      for (int k = 0; k < N; k++)
         if (vv[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         req_op[i*4 +: 4]    = op[i];
         req_src1[i*32 +: 32] = a[i];
         req_src2[i*32 +: 32] = b[i];
      end
      req_valid = v;
      rsp_ready = rr;
   endtask

   task automatic cyc();
      apply();
      @(negedge clk);
      #2;
      last_acc = req_valid & req_ready;
      @(posedge clk);
      #1;
   endtask

   // Reference model: predicts handshakes and pushes expected responses.
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         m_hold  = 1'b0;
         m_owner = 0;
         m_ptr   = 0;
         chk("ready_in_reset", 32'(req_ready), 32'd0);
      end else begin
         m_ev = m_hold ? (N'(1) << m_owner) : '0;
         chk("rsp_valid_model", 32'(rsp_valid), 32'(m_ev));
         m_drn = m_hold && rsp_ready[m_owner];
         m_w   = pick(req_valid, m_ptr);
         m_er  = '0;
         if (m_w >= 0 && (!m_hold || m_drn)) m_er[m_w] = 1'b1;
         chk("req_ready", 32'(req_ready), 32'(m_er));
         if (m_er != '0) begin
            q.push_back('{m_w, alu_ref(req_op[m_w*4 +: 4], req_src1[m_w*32 +: 32], req_src2[m_w*32 +: 32])});
            m_hold  = 1'b1;
            m_owner = m_w;
`ifdef HOLY_ALU_ARB_RR_EN
            m_ptr   = (m_w + 1) % N;
`endif
         end else if (m_drn) begin
            m_hold = 1'b0;
         end
      end
   end

   // Monitor: compares every presented response against the scoreboard head.
   always @(negedge clk) begin
      if (rst_n && rsp_valid != '0) begin
         if (q.size() == 0) begin
            n_chk++;
            $display("FAIL rsp_unexpected: got rsp_valid %b expected none", rsp_valid);
         end else begin
            chk("rsp_owner", 32'(rsp_valid), 32'(N'(1) << q[0].owner));
            chk("rsp_result", rsp_result, q[0].res);
            chk("rsp_zero", 32'(rsp_zero), 32'(q[0].res == 32'd0));
            chk("rsp_last_bit", 32'(rsp_last_bit), 32'(q[0].res[0]));
            if ((rsp_valid & rsp_ready) != '0) void'(q.pop_front());
         end
      end
   end

   logic [N-1:0] grants [4];
   logic [N-1:0] exp_grants [4];

   initial begin
      for (int i = 0; i < N; i++) begin
         op[i] = 4'd0; a[i] = 32'd0; b[i] = 32'd0;
      end

      // reset values
      repeat (3) cyc();
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_result", rsp_result, 32'd0);
      chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
      chk("rst_rsp_last_bit", 32'(rsp_last_bit), 32'd0);
      rst_n = 1'b1;
      cyc();

      // reset asserted while a response is held
      v = 2'b01; op[0] = ALU_ADD; a[0] = 32'd5; b[0] = 32'd7; rr = '0;
      cyc();
      chk("hold_before_rst", 32'(rsp_valid), 32'd1);
      v = '0;
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_rsp_result", rsp_result, 32'd0);
      q.delete();
      cyc();
      rst_n = 1'b1;
      repeat (2) cyc();

      // single op on requester 1
      v = 2'b10; op[1] = ALU_SUB; a[1] = 32'd10; b[1] = 32'd3; rr = 2'b10;
      cyc();
      chk("single_valid", 32'(rsp_valid), 32'h2);
      chk("single_result", rsp_result, 32'd7);
      chk("single_zero", 32'(rsp_zero), 32'd0);
      chk("single_last", 32'(rsp_last_bit), 32'd1);
      v = '0;
      cyc();

      // contention with everything ready
      v = 2'b11; rr = 2'b11;
      op[0] = ALU_ADD; a[0] = 32'd100; b[0] = 32'd1;
      op[1] = ALU_OR;  a[1] = 32'hF0;  b[1] = 32'h0F;
`ifdef HOLY_ALU_ARB_RR_EN
      exp_grants = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
      exp_grants = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
      for (int c = 0; c < 4; c++) begin
         cyc();
         grants[c] = last_acc;
      end
      for (int c = 0; c < 4; c++) chk("contention_grant", 32'(grants[c]), 32'(exp_grants[c]));
      v = '0;
      cyc();

      // backpressure: SLT held three cycles while requester 1 waits
      v = 2'b01; op[0] = ALU_SLT; a[0] = 32'hFFFF_FFFF; b[0] = 32'd1; rr = '0;
      cyc();
      v = 2'b10; op[1] = ALU_ADD; a[1] = 32'd1; b[1] = 32'd2;
      repeat (3) begin
         cyc();
         chk("bp_ready_low", 32'(last_acc), 32'd0);
         chk("bp_result_held", rsp_result, 32'd1);
      end
      rr = 2'b01;
      cyc();
      chk("bp_accept_on_drain", 32'(last_acc), 32'h2);
      chk("bp_new_owner", 32'(rsp_valid), 32'h2);
      v = '0; rr = 2'b10;
      cyc();

      // zero flag then back-to-back arithmetic shift
      v = 2'b01; op[0] = ALU_XOR; a[0] = 32'hDEAD_BEEF; b[0] = 32'hDEAD_BEEF; rr = 2'b01;
      cyc();
      chk("xor_zero", 32'(rsp_zero), 32'd1);
      chk("xor_result", rsp_result, 32'd0);
      op[0] = ALU_SRA; a[0] = 32'h8000_0000; b[0] = 32'd31;
      cyc();
      chk("sra_b2b_accept", 32'(last_acc), 32'h1);
      chk("sra_result", rsp_result, 32'hFFFF_FFFF);
      chk("sra_zero", 32'(rsp_zero), 32'd0);

      // only the non-owner signals ready: response must stay put
      v = '0; rr = 2'b10;
      repeat (2) begin
         cyc();
         chk("wrong_owner_hold", 32'(rsp_valid), 32'h1);
         chk("wrong_owner_result", rsp_result, 32'hFFFF_FFFF);
      end
      rr = 2'b01;
      cyc();
      chk("owner_drained", 32'(rsp_valid), 32'd0);

      // randomized traffic, honouring the hold-while-not-ready rule
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!(v[i] && !last_acc[i])) begin
               v[i]  = ($urandom_range(0, 2) != 0);
               op[i] = 4'($urandom_range(0, 11));
               a[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : 32'($urandom);
               b[i]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            end
         end
         rr = N'($urandom);
         cyc();
      end

      v = '0; rr = '1;
      repeat (3) cyc();
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
